// File: rtl/csram_bank_arbiter.sv
// N-master x M-bank CSRAM crossbar: per-bank round-robin arbitration with read-data return via per-master tag pipelines.
// Optional CSRAM_ARB_DBG_PRIO_EN: master 0 (debug bridge) wins every bank it targets without moving the round-robin pointer.
module csram_bank_arbiter #(
  parameter int unsigned NUM_MASTERS = 3,
  parameter int unsigned NUM_BANKS   = 4,
  parameter int unsigned BANK_AW     = 10,
  parameter int unsigned DW          = 32,
  parameter int unsigned RD_LATENCY  = 1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUM_MASTERS-1:0]          m_req,
  input  logic [NUM_MASTERS-1:0]          m_we,
  input  logic [NUM_MASTERS*32-1:0]       m_addr,
  input  logic [NUM_MASTERS*DW-1:0]       m_wdata,
  input  logic [NUM_MASTERS*(DW/8)-1:0]   m_be,
  output logic [NUM_MASTERS-1:0]          m_gnt,
  output logic [NUM_MASTERS-1:0]          m_rvalid,
  output logic [NUM_MASTERS*DW-1:0]       m_rdata,
  output logic [NUM_BANKS-1:0]            sram_cs,
  output logic [NUM_BANKS*BANK_AW-1:0]    sram_addr,
  output logic [NUM_BANKS*DW-1:0]         sram_wdata,
  output logic [NUM_BANKS*(DW/8)-1:0]     sram_wen,
  input  logic [NUM_BANKS*DW-1:0]         sram_rdata
);

  localparam int unsigned AW  = 32;
  localparam int unsigned BW  = $clog2(NUM_BANKS);
  localparam int unsigned MW  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int unsigned BEW = DW / 8;
  localparam int unsigned UW  = AW - BANK_AW - BW;
`ifdef CSRAM_ARB_DBG_PRIO_EN
  localparam bit DBG_PRIO = 1'b1;
`else
  localparam bit DBG_PRIO = 1'b0;
`endif

  logic [NUM_BANKS-1:0] cand      [NUM_MASTERS];
  logic [MW-1:0]        rr_ptr    [NUM_BANKS];
  logic [MW-1:0]        win_idx   [NUM_BANKS];
  logic [NUM_BANKS-1:0] win_valid;
  logic [NUM_BANKS-1:0] rr_adv;
  logic                 unused_addr_bits;

  // Master 0's tag pipeline is pipeline 0, so the master index is implicit.
  logic [RD_LATENCY-1:0] tag_v    [NUM_MASTERS];
  logic [BW-1:0]         tag_bank [NUM_MASTERS][RD_LATENCY];
  logic [DW-1:0]         rd_sel   [NUM_MASTERS];

  // Bank decode; reset masks every candidate so grants and chip selects stay low.
  always_comb begin
    unused_addr_bits = 1'b0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      unused_addr_bits = unused_addr_bits ^ (^m_addr[i*AW+BANK_AW+BW +: UW]);
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
        cand[i][b] = m_req[i] && !rst_i && (m_addr[i*AW+BANK_AW +: BW] == BW'(b));
      end
    end
  end

  // Per-bank winner: first candidate at or after rr_ptr, wrapping modulo NUM_MASTERS.
  always_comb begin : arb
    int unsigned idx;
    idx = 0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      win_valid[b] = 1'b0;
      win_idx[b]   = '0;
      rr_adv[b]    = 1'b0;
      if (DBG_PRIO && cand[0][b]) begin
        win_valid[b] = 1'b1;
      end
      for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
        idx = (32'(rr_ptr[b]) + k) % NUM_MASTERS;
        if (!win_valid[b] && cand[MW'(idx)][b] && !(DBG_PRIO && idx == 0)) begin
          win_valid[b] = 1'b1;
          win_idx[b]   = MW'(idx);
          rr_adv[b]    = 1'b1;
        end
      end
    end
  end

  // Grant fan-out and bank drive from each winner; idle banks drive zeros.
  always_comb begin
    m_gnt      = '0;
    sram_cs    = win_valid;
    sram_addr  = '0;
    sram_wdata = '0;
    sram_wen   = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
        if (win_valid[b] && win_idx[b] == MW'(i)) begin
          m_gnt[i]                         = 1'b1;
          sram_addr[b*BANK_AW +: BANK_AW]  = m_addr[i*AW +: BANK_AW];
          sram_wdata[b*DW +: DW]           = m_wdata[i*DW +: DW];
          sram_wen[b*BEW +: BEW]           = m_we[i] ? m_be[i*BEW +: BEW] : '0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned b = 0; b < NUM_BANKS; b++) rr_ptr[b] <= '0;
    end else begin
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
        if (rr_adv[b]) begin
          rr_ptr[b] <= (win_idx[b] == MW'(NUM_MASTERS - 1)) ? '0 : win_idx[b] + MW'(1);
        end
      end
    end
  end

  // Bank data selected by the tag leaving each master's pipeline.
  always_comb begin
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      rd_sel[i] = '0;
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
        if (tag_bank[i][RD_LATENCY-1] == BW'(b)) rd_sel[i] = sram_rdata[b*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_rvalid <= '0;
      m_rdata  <= '0;
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
        tag_v[i] <= '0;
        for (int unsigned s = 0; s < RD_LATENCY; s++) tag_bank[i][s] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
        tag_v[i][0]    <= m_gnt[i] && !m_we[i];
        tag_bank[i][0] <= m_addr[i*AW+BANK_AW +: BW];
        for (int unsigned s = 1; s < RD_LATENCY; s++) begin
          tag_v[i][s]    <= tag_v[i][s-1];
          tag_bank[i][s] <= tag_bank[i][s-1];
        end
        m_rvalid[i] <= tag_v[i][RD_LATENCY-1];
        if (tag_v[i][RD_LATENCY-1]) m_rdata[i*DW +: DW] <= rd_sel[i];
      end
    end
  end

endmodule

// File: tb/tb_csram_bank_arbiter.sv
// Directed bench for csram_bank_arbiter with a behavioural 1-cycle-latency SRAM per bank.
// The final block exercises CSRAM_ARB_DBG_PRIO_EN when the macro is defined.
module tb_csram_bank_arbiter;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [2:0]   m_req;
  logic [2:0]   m_we;
  logic [95:0]  m_addr;
  logic [95:0]  m_wdata;
  logic [11:0]  m_be;
  logic [2:0]   m_gnt;
  logic [2:0]   m_rvalid;
  logic [95:0]  m_rdata;
  logic [3:0]   sram_cs;
  logic [39:0]  sram_addr;
  logic [127:0] sram_wdata;
  logic [15:0]  sram_wen;
  logic [127:0] sram_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [4][1024];

  csram_bank_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .sram_cs(sram_cs), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_wen(sram_wen), .sram_rdata(sram_rdata)
  );

  always #5 clk_i = ~clk_i;

  // Bank SRAMs: pattern-filled, read-before-write, one cycle read latency.
  initial begin
    for (int b = 0; b < 4; b++)
      for (int r = 0; r < 1024; r++)
        mem[b][r] = 32'hA000_0000 | (32'(b) << 12) | 32'(r);
    mem[2][5] = 32'hDEAD_BEEF;
    sram_rdata = '0;
    forever begin
      @(posedge clk_i);
      for (int b = 0; b < 4; b++) begin
        if (sram_cs[b]) begin
          sram_rdata[b*32 +: 32] <= mem[b][sram_addr[b*10 +: 10]];
          for (int j = 0; j < 4; j++)
            if (sram_wen[b*4+j])
              mem[b][sram_addr[b*10 +: 10]][j*8 +: 8] = sram_wdata[b*32+j*8 +: 8];
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int i, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] be);
    m_we[i]            = we;
    m_addr[i*32 +: 32] = addr;
    m_wdata[i*32 +: 32] = wd;
    m_be[i*4 +: 4]     = be;
  endtask

  initial begin
    rst_i = 1'b1; m_req = '0; m_we = '0; m_addr = '0; m_wdata = '0; m_be = '0;

    // Reset: grants and chip selects forced low even with requests present.
    @(negedge clk_i);
    m_req = 3'b111;
    #1;
    check("rst_gnt", 64'(m_gnt), 64'(3'b000));
    check("rst_cs", 64'(sram_cs), 64'(4'b0000));
    check("rst_rvalid", 64'(m_rvalid), 64'(3'b000));
    check("rst_rdata", 64'(m_rdata[63:0]), 64'h0);
    @(negedge clk_i);
    m_req = '0; rst_i = 1'b0;

    // Single read: M1, bank 2 row 5.
    @(negedge clk_i);
    drive(1, 1'b0, 32'h805, 32'h0, 4'h0); m_req = 3'b010;
    #1;
    check("t1_gnt", 64'(m_gnt), 64'(3'b010));
    check("t1_cs", 64'(sram_cs), 64'(4'b0100));
    check("t1_addr", 64'(sram_addr[20 +: 10]), 64'd5);
    check("t1_wen", 64'(sram_wen[8 +: 4]), 64'h0);
    @(negedge clk_i);
    m_req = '0;
    #1 check("t1_rvalid_early", 64'(m_rvalid), 64'(3'b000));
    @(negedge clk_i);
    #1;
    check("t1_rvalid", 64'(m_rvalid), 64'(3'b010));
    check("t1_rdata", 64'(m_rdata[32 +: 32]), 64'hDEAD_BEEF);
    @(negedge clk_i);
    #1;
    check("t1_rvalid_off", 64'(m_rvalid), 64'(3'b000));
    check("t1_rdata_hold", 64'(m_rdata[32 +: 32]), 64'hDEAD_BEEF);

    // Parallel banks: M0 writes bank 0, M2 reads bank 3.
    @(negedge clk_i);
    drive(0, 1'b1, 32'h003, 32'h11, 4'hF);
    drive(2, 1'b0, 32'hC07, 32'h0, 4'h0);
    m_req = 3'b101;
    #1;
    check("t2_gnt", 64'(m_gnt), 64'(3'b101));
    check("t2_cs", 64'(sram_cs), 64'(4'b1001));
    check("t2_wen0", 64'(sram_wen[0 +: 4]), 64'hF);
    check("t2_wen3", 64'(sram_wen[12 +: 4]), 64'h0);
    check("t2_wdata0", 64'(sram_wdata[0 +: 32]), 64'h11);
    check("t2_addr3", 64'(sram_addr[30 +: 10]), 64'd7);
    @(negedge clk_i);
    m_req = '0;
    #1 check("t2_rvalid_early", 64'(m_rvalid), 64'(3'b000));
    @(negedge clk_i);
    #1;
    check("t2_rvalid", 64'(m_rvalid), 64'(3'b100));
    check("t2_rdata2", 64'(m_rdata[64 +: 32]), 64'hA000_3007);
    @(negedge clk_i);
    drive(1, 1'b0, 32'h003, 32'h0, 4'h0); m_req = 3'b010;
    #1 check("t2_rb_gnt", 64'(m_gnt), 64'(3'b010));
    @(negedge clk_i);
    m_req = '0;
    @(negedge clk_i);
    #1;
    check("t2_rb_rvalid", 64'(m_rvalid), 64'(3'b010));
    check("t2_rb_rdata", 64'(m_rdata[32 +: 32]), 64'h11);

    // Contention: all three read bank 1.
    @(negedge clk_i);
    drive(0, 1'b0, 32'h401, 32'h0, 4'h0);
    drive(1, 1'b0, 32'h402, 32'h0, 4'h0);
    drive(2, 1'b0, 32'h403, 32'h0, 4'h0);
    m_req = 3'b111;
    #1 check("t3_gnt0", 64'(m_gnt), 64'(3'b001));
    @(negedge clk_i);
    m_req = 3'b110;
    #1;
    check("t3_gnt1", 64'(m_gnt), 64'(3'b010));
    check("t3_rv0", 64'(m_rvalid), 64'(3'b000));
    @(negedge clk_i);
    m_req = 3'b100;
    #1;
    check("t3_gnt2", 64'(m_gnt), 64'(3'b100));
    check("t3_rv1", 64'(m_rvalid), 64'(3'b001));
    check("t3_rd0", 64'(m_rdata[0 +: 32]), 64'hA000_1001);
    @(negedge clk_i);
    m_req = '0;
    #1;
    check("t3_rv2", 64'(m_rvalid), 64'(3'b010));
    check("t3_rd1", 64'(m_rdata[32 +: 32]), 64'hA000_1002);
    @(negedge clk_i);
    #1;
    check("t3_rv3", 64'(m_rvalid), 64'(3'b100));
    check("t3_rd2", 64'(m_rdata[64 +: 32]), 64'hA000_1003);

    // Zero-byte-enable write moves rr_ptr[1] to 2, then M0 wins by wrap.
    @(negedge clk_i);
    drive(1, 1'b1, 32'h409, 32'hFFFF_FFFF, 4'h0); m_req = 3'b010;
    #1;
    check("t4_be0_gnt", 64'(m_gnt), 64'(3'b010));
    check("t4_be0_cs", 64'(sram_cs), 64'(4'b0010));
    check("t4_be0_wen", 64'(sram_wen[4 +: 4]), 64'h0);
    @(negedge clk_i);
    drive(0, 1'b0, 32'h401, 32'h0, 4'h0);
    drive(1, 1'b0, 32'h409, 32'h0, 4'h0);
    m_req = 3'b011;
    #1 check("t4_gnt_wrap", 64'(m_gnt), 64'(3'b001));
    @(negedge clk_i);
    m_req = 3'b010;
    #1;
    check("t4_gnt_m1", 64'(m_gnt), 64'(3'b010));
    check("t4_no_wr_rv", 64'(m_rvalid), 64'(3'b000));
    @(negedge clk_i);
    m_req = '0;
    #1;
    check("t4_rv0", 64'(m_rvalid), 64'(3'b001));
    check("t4_rd0", 64'(m_rdata[0 +: 32]), 64'hA000_1001);
    @(negedge clk_i);
    #1;
    check("t4_rv1", 64'(m_rvalid), 64'(3'b010));
    check("t4_mem_kept", 64'(m_rdata[32 +: 32]), 64'hA000_1009);

    // Reset mid-read: in-flight read dropped, pointers back to 0.
    @(negedge clk_i);
    drive(1, 1'b0, 32'h402, 32'h0, 4'h0); m_req = 3'b010;
    #1 check("t5_gnt", 64'(m_gnt), 64'(3'b010));
    @(negedge clk_i);
    drive(0, 1'b0, 32'h401, 32'h0, 4'h0);
    drive(2, 1'b0, 32'h403, 32'h0, 4'h0);
    m_req = 3'b111; rst_i = 1'b1;
    #1;
    check("t5_rst_gnt", 64'(m_gnt), 64'(3'b000));
    check("t5_rst_cs", 64'(sram_cs), 64'(4'b0000));
    rst_i = 1'b0;
    #1 check("t5_post_gnt", 64'(m_gnt), 64'(3'b001));
    @(negedge clk_i);
    m_req = 3'b110;
    #1;
    check("t5_dropped_rv", 64'(m_rvalid), 64'(3'b000));
    check("t5_rdata_clr", 64'(m_rdata[63:0]), 64'h0);
    check("t5_gnt1", 64'(m_gnt), 64'(3'b010));
    @(negedge clk_i);
    m_req = 3'b100;
    #1;
    check("t5_rv0", 64'(m_rvalid), 64'(3'b001));
    check("t5_rd0", 64'(m_rdata[0 +: 32]), 64'hA000_1001);
    @(negedge clk_i);
    m_req = '0;
    #1 check("t5_rv1", 64'(m_rvalid), 64'(3'b010));
    @(negedge clk_i);
    #1 check("t5_rv2", 64'(m_rvalid), 64'(3'b100));

`ifdef CSRAM_ARB_DBG_PRIO_EN
    // Master 0 starves master 1 on bank 0 until it drops its request.
    @(negedge clk_i);
    drive(0, 1'b0, 32'h000, 32'h0, 4'h0);
    drive(1, 1'b0, 32'h001, 32'h0, 4'h0);
    m_req = 3'b011;
    for (int c = 0; c < 3; c++) begin
      #1 check("dbg_prio", 64'(m_gnt), 64'(3'b001));
      @(negedge clk_i);
    end
    m_req = 3'b010;
    #1 check("dbg_release", 64'(m_gnt), 64'(3'b010));
    @(negedge clk_i);
    m_req = '0;
`endif

    repeat (3) @(negedge clk_i);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
